// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access-size, completion-status and FSM-state encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_TIMEOUT = 2'b10
    } lsu_err_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } lsu_state_e;

    // Illegal size counts as misaligned so both share the error-01 path.
    function automatic logic misaligned(input lsu_size_e size, input logic [1:0] a);
        return (size == SZ_ILL) || (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extraction with sign/zero extension, store lane replication and byte enables.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be
);

    logic [31:0] sh;

    assign sh = mem_rdata >> {addr_lo, 3'b000};

    assign load_data = size == SZ_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} :
                       size == SZ_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : mem_rdata;

    assign mem_be = size == SZ_BYTE ? 4'b0001 << addr_lo :
                    size == SZ_HALF ? 4'b0011 << addr_lo :
                    size == SZ_WORD ? 4'b1111 : 4'b0000;

    assign mem_wdata = size == SZ_BYTE ? {4{wdata[7:0]}} :
                       size == SZ_HALF ? {2{wdata[15:0]}} : wdata;

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller (IDLE/ISSUE/DONE) with alignment checking.
// Define LSU_TIMEOUT_EN to abort an ISSUE that sees no ready within TIMEOUT cycles.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        LSU_req,
    input  logic        LSU_we,
    input  logic [1:0]  LSU_size,
    input  logic        LSU_unsigned,
    input  logic [31:0] LSU_addr,
    input  logic [31:0] LSU_wdata,
    output logic        LSU_busy,
    output logic        LSU_done,
    output logic [31:0] LSU_rdata,
    output logic [1:0]  LSU_error,
    output logic        LSU_mem_read,
    output logic        LSU_mem_write,
    output logic [31:0] LSU_mem_addr,
    output logic [31:0] LSU_mem_wdata,
    output logic [3:0]  LSU_mem_be,
    input  logic        LSU_mem_ready,
    input  logic [31:0] LSU_mem_rdata
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("lsu_ctrl: TIMEOUT must be in 2..255");
    end

    lsu_state_e  state_q, state_d;
    lsu_err_e    err_q, err_d;
    lsu_size_e   size_q;
    logic        we_q, uns_q, latch, issue;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic [31:0] load_data, al_wdata;
    logic [3:0]  al_be;
`ifdef LSU_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
`endif

    lsu_align u_align (
        .size      (size_q),
        .addr_lo   (addr_q[1:0]),
        .uns       (uns_q),
        .wdata     (wdata_q),
        .mem_rdata (LSU_mem_rdata),
        .load_data (load_data),
        .mem_wdata (al_wdata),
        .mem_be    (al_be)
    );

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q <= IDLE;
            err_q   <= ERR_OK;
            rdata_q <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
            if (latch) begin
                we_q    <= LSU_we;
                uns_q   <= LSU_unsigned;
                size_q  <= lsu_size_e'(LSU_size);
                addr_q  <= LSU_addr;
                wdata_q <= LSU_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        latch   = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (LSU_req) begin
                rdata_d = '0;
                if (misaligned(lsu_size_e'(LSU_size), LSU_addr[1:0])) begin
                    state_d = DONE;
                    err_d   = ERR_ALIGN;
                end else begin
                    state_d = ISSUE;
                    err_d   = ERR_OK;
                    latch   = 1'b1;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ISSUE: if (LSU_mem_ready) begin
                state_d = DONE;
                err_d   = ERR_OK;
                rdata_d = we_q ? '0 : load_data;
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt_q == 8'(TIMEOUT - 1)) begin
                state_d = DONE;
                err_d   = ERR_TIMEOUT;
                rdata_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Every output is derived from reset-cleared state, so reset zeroes them immediately.
    assign issue         = state_q == ISSUE;
    assign LSU_busy      = state_q != IDLE;
    assign LSU_done      = state_q == DONE;
    assign LSU_rdata     = LSU_done ? rdata_q : '0;
    assign LSU_error     = LSU_done ? err_q : ERR_OK;
    assign LSU_mem_read  = issue & ~we_q;
    assign LSU_mem_write = issue & we_q;
    assign LSU_mem_addr  = issue ? {addr_q[31:2], 2'b00} : '0;
    assign LSU_mem_wdata = LSU_mem_write ? al_wdata : '0;
    assign LSU_mem_be    = LSU_mem_write ? al_be : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench; a memory responder and a completion monitor check against queued expectations.
module tb_lsu_ctrl;

    logic        SYS_clk = 0;
    logic        SYS_reset = 0;
    logic        LSU_req = 0, LSU_we = 0, LSU_unsigned = 0;
    logic [1:0]  LSU_size = 0;
    logic [31:0] LSU_addr = 0, LSU_wdata = 0;
    logic        LSU_busy, LSU_done, LSU_mem_read, LSU_mem_write;
    logic [31:0] LSU_rdata, LSU_mem_addr, LSU_mem_wdata;
    logic [1:0]  LSU_error;
    logic [3:0]  LSU_mem_be;
    logic        LSU_mem_ready = 0;
    logic [31:0] LSU_mem_rdata = 0;

    typedef struct {logic [31:0] rdata; logic [1:0] err; int lat; int t0;} done_t;
    typedef struct {logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} mem_t;

    done_t exp_q[$];
    mem_t  mem_q[$];
    mem_t  cur;
    int    checks = 0, errors = 0, cyc = 0, wait_cnt = 0, rdy_delay = 0;
    logic [31:0] mem_word = 0;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .LSU_req(LSU_req), .LSU_we(LSU_we),
        .LSU_size(LSU_size), .LSU_unsigned(LSU_unsigned), .LSU_addr(LSU_addr), .LSU_wdata(LSU_wdata),
        .LSU_busy(LSU_busy), .LSU_done(LSU_done), .LSU_rdata(LSU_rdata), .LSU_error(LSU_error),
        .LSU_mem_read(LSU_mem_read), .LSU_mem_write(LSU_mem_write), .LSU_mem_addr(LSU_mem_addr),
        .LSU_mem_wdata(LSU_mem_wdata), .LSU_mem_be(LSU_mem_be), .LSU_mem_ready(LSU_mem_ready),
        .LSU_mem_rdata(LSU_mem_rdata)
    );

    always #5 SYS_clk = ~SYS_clk;
    always @(posedge SYS_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: checks strobe contents every ISSUE cycle, raises ready after rdy_delay cycles.
    always @(negedge SYS_clk) begin
        if (LSU_mem_read || LSU_mem_write) begin
            if (wait_cnt == 0) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got rd=%b wr=%b expected none", LSU_mem_read, LSU_mem_write);
                    cur = '{rd: 1'b0, wr: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0};
                end else cur = mem_q.pop_front();
            end
            chk("mem_read", {31'b0, LSU_mem_read}, {31'b0, cur.rd});
            chk("mem_write", {31'b0, LSU_mem_write}, {31'b0, cur.wr});
            chk("mem_addr", LSU_mem_addr, cur.addr);
            if (cur.wr) begin
                chk("mem_wdata", LSU_mem_wdata, cur.wdata);
                chk("mem_be", {28'b0, LSU_mem_be}, {28'b0, cur.be});
            end
            LSU_mem_ready = wait_cnt >= rdy_delay;
            LSU_mem_rdata = mem_word;
            wait_cnt++;
        end else begin
            LSU_mem_ready = 0;
            LSU_mem_rdata = 0;
            wait_cnt = 0;
        end
    end

    // Completion monitor.
    always @(negedge SYS_clk) begin
        if (LSU_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                done_t e;
                e = exp_q.pop_front();
                chk("rdata", LSU_rdata, e.rdata);
                chk("error", {30'b0, LSU_error}, {30'b0, e.err});
                chk("latency", cyc - e.t0, e.lat);
                chk("done_strobes", {30'b0, LSU_mem_read, LSU_mem_write}, 32'h0);
                chk("done_busy", {31'b0, LSU_busy}, 32'h1);
            end
        end
    end

    task automatic req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] mw, input int dly, input logic strobe,
                       input logic [31:0] ewd, input logic [3:0] ebe, input logic [31:0] erd,
                       input logic [1:0] eerr, input int elat);
        int i;
        @(negedge SYS_clk);
        LSU_req = 1; LSU_we = we; LSU_size = sz; LSU_unsigned = uns; LSU_addr = a; LSU_wdata = wd;
        rdy_delay = dly;
        mem_word = mw;
        exp_q.push_back('{rdata: erd, err: eerr, lat: elat, t0: cyc});
        if (strobe) mem_q.push_back('{rd: ~we, wr: we, addr: {a[31:2], 2'b00}, wdata: ewd, be: ebe});
        @(negedge SYS_clk);
        LSU_req = 0;
        for (i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge SYS_clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", i);
            exp_q.delete();
        end
        @(negedge SYS_clk);
        chk("idle_busy", {31'b0, LSU_busy}, 32'h0);
        chk("idle_strobes", {30'b0, LSU_mem_read, LSU_mem_write}, 32'h0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {23'b0, LSU_busy, LSU_done, LSU_error, LSU_mem_read, LSU_mem_write, LSU_mem_be}, 32'h0);
        chk({name, "_rdata"}, LSU_rdata, 32'h0);
        chk({name, "_maddr"}, LSU_mem_addr, 32'h0);
        chk({name, "_mwdata"}, LSU_mem_wdata, 32'h0);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge SYS_clk);
        chk_all_zero("reset");
        SYS_reset = 1;
        //  we  sz     uns  addr          wdata         memword       dly str ewdata        ebe      erdata        err    lat
        req(0, 2'b10, 0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 0, 1, 32'h0,        4'b0000, 32'hDEAD_BEEF, 2'b00, 2);
        req(0, 2'b00, 0, 32'h0000_0013, 32'h0,        32'h80FF_0000, 0, 1, 32'h0,        4'b0000, 32'hFFFF_FF80, 2'b00, 2);
        req(0, 2'b00, 1, 32'h0000_0013, 32'h0,        32'h80FF_0000, 0, 1, 32'h0,        4'b0000, 32'h0000_0080, 2'b00, 2);
        req(1, 2'b01, 0, 32'h0000_0022, 32'h0000_ABCD, 32'hFFFF_FFFF, 0, 1, 32'hABCD_ABCD, 4'b1100, 32'h0,        2'b00, 2);
        req(0, 2'b10, 0, 32'h0000_0005, 32'h0,        32'h1111_1111, 0, 0, 32'h0,        4'b0000, 32'h0,        2'b01, 1);
        req(0, 2'b11, 0, 32'h0000_0000, 32'h0,        32'h1111_1111, 0, 0, 32'h0,        4'b0000, 32'h0,        2'b01, 1);
        req(0, 2'b01, 0, 32'h0000_0001, 32'h0,        32'h1111_1111, 0, 0, 32'h0,        4'b0000, 32'h0,        2'b01, 1);
        req(0, 2'b01, 0, 32'h0000_0002, 32'h0,        32'h8001_1234, 3, 1, 32'h0,        4'b0000, 32'hFFFF_8001, 2'b00, 5);
        req(0, 2'b01, 1, 32'h0000_0000, 32'h0,        32'h1234_F00D, 0, 1, 32'h0,        4'b0000, 32'h0000_F00D, 2'b00, 2);
        req(1, 2'b00, 0, 32'h0000_0011, 32'h0000_00A5, 32'h0,        1, 1, 32'hA5A5_A5A5, 4'b0010, 32'h0,        2'b00, 3);
        req(1, 2'b10, 0, 32'h0000_000C, 32'h1234_5678, 32'h0,        0, 1, 32'h1234_5678, 4'b1111, 32'h0,        2'b00, 2);
        req(0, 2'b00, 0, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 1, 32'h0,        4'b0000, 32'h0000_007F, 2'b00, 2);
`ifdef LSU_TIMEOUT_EN
        req(0, 2'b10, 0, 32'h0000_0040, 32'h0,        32'h0,        1000, 1, 32'h0,     4'b0000, 32'h0,        2'b10, 5);
`else
        req(0, 2'b10, 0, 32'h0000_0040, 32'h0,        32'hCAFE_F00D, 20, 1, 32'h0,      4'b0000, 32'hCAFE_F00D, 2'b00, 22);
`endif
        // Reset in the third ISSUE cycle of a stalled load.
        @(negedge SYS_clk);
        LSU_req = 1; LSU_we = 0; LSU_size = 2'b10; LSU_unsigned = 0; LSU_addr = 32'h30;
        rdy_delay = 1000;
        mem_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h30, wdata: 32'h0, be: 4'h0});
        @(negedge SYS_clk);
        LSU_req = 0;
        @(negedge SYS_clk);
        @(negedge SYS_clk);
        chk("pre_reset_read", {31'b0, LSU_mem_read}, 32'h1);
        #2 SYS_reset = 0;
        #1 chk_all_zero("midreset");
        @(negedge SYS_clk);
        SYS_reset = 1;
        repeat (3) @(negedge SYS_clk);
        chk("post_reset_busy", {31'b0, LSU_busy}, 32'h0);
        req(0, 2'b10, 0, 32'h0000_0048, 32'h0,        32'h0BAD_CAFE, 0, 1, 32'h0,        4'b0000, 32'h0BAD_CAFE, 2'b00, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
